systolic_array_ws: RTL and testbench
====================================

SYSTOLIC_ARRAY_WS -- requirements
Module: systolic_array_ws

Interface
REQ-001 SHALL have parameter WIDTH, default 16, signed width of activations and weights.
REQ-002 SHALL have parameter N, default 4, array rows = columns (N >= 2).
REQ-003 SHALL have parameter ACC_WIDTH, default 2*WIDTH+$clog2(N), signed partial-sum/result width.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port w_valid  input  1  weight row beat valid.
REQ-007 SHALL have port w_ready  output  1  weight row beat accepted when w_valid && w_ready.
REQ-008 SHALL have port w_row  input  N x WIDTH signed  weights W[r][0..N-1] for current row r.
REQ-009 SHALL have port a_valid  input  1  activation vector valid.
REQ-010 SHALL have port a_ready  output  1  activation vector accepted when a_valid && a_ready.
REQ-011 SHALL have port a_in  input  N x WIDTH signed  activation vector a[0..N-1], element i feeds row i.
REQ-012 SHALL have port a_last  input  1  marks final vector of a batch; sampled with accepted beat.
REQ-013 SHALL have port res_valid  output  1  one-cycle qualifier for res_out; no backpressure.
REQ-014 SHALL have port res_out  output  N x ACC_WIDTH signed  y[j] = sum over i of a[i]*W[i][j].
REQ-015 SHALL have port busy  output  1  high in LOAD, COMPUTE, DRAIN.
REQ-016 SHALL have port weights_loaded  output  1  high once a full N-row weight set is resident.

Function
REQ-017 SHALL implement an NxN weight-stationary grid: activations move right one PE per cycle, partial sums move down one PE per cycle, bottom of column j yields y[j].
REQ-018 SHALL skew row i input by i cycles and de-skew column j output by N-1-j cycles so all y[j] of one vector emerge on the same cycle.
REQ-019 SHALL present res_valid exactly 2N cycles after the accepting edge of the corresponding vector, constant, in order.
REQ-020 SHALL sign-extend products to ACC_WIDTH and accumulate in two's complement; overflow wraps (no saturation).
REQ-021 SHALL implement FSM states IDLE, LOAD, COMPUTE, DRAIN.
REQ-022 IDLE: w_ready=1; a_ready=weights_loaded; accepted w beat -> LOAD (row 0 written); else accepted a beat -> COMPUTE.
REQ-023 IDLE with w_valid and a_valid both high SHALL accept only the weight beat (weights take precedence; a_ready=0 that cycle).
REQ-024 LOAD: w_ready=1, a_ready=0; row counter 0..N-1 increments per accepted beat; weights_loaded=0 from first beat until beat N-1 accepted, then -> IDLE with weights_loaded=1; counter wraps to 0.
REQ-025 LOAD with w_valid low SHALL hold row counter and state (stalls allowed).
REQ-026 COMPUTE: a_ready=1, w_ready=0; a_valid low cycles inject bubbles that produce no res_valid; accepted beat with a_last=1 -> DRAIN.
REQ-027 An a_last beat accepted directly in IDLE SHALL go straight to DRAIN.
REQ-028 DRAIN: a_ready=0, w_ready=0; counter runs 2N cycles, final res_valid occurs on last DRAIN cycle, then -> IDLE; weights retained.
REQ-029 Weights SHALL remain unchanged throughout COMPUTE and DRAIN.

Reset
REQ-030 rst low SHALL asynchronously force state IDLE, all weights, pipeline, skew and de-skew registers and counters to 0, weights_loaded=0, res_valid=0, res_out=0, busy=0, a_ready=0, w_ready=1 (after release).
REQ-031 Reset mid-LOAD/COMPUTE/DRAIN SHALL discard in-flight vectors; no res_valid until new weights and vectors are accepted.

Verification
REQ-032 N=4,WIDTH=16: load identity W, send a=[1,2,3,4] a_last=1 -> res_valid 8 cycles after acceptance, res_out=[1,2,3,4], then IDLE, busy=0.
REQ-033 W all -1, a=[32767,32767,32767,32767] -> res_out each = -131068 (no wrap at ACC_WIDTH=34).
REQ-034 W[i][j]=i+1, vectors [1,1,1,1],bubble,[2,0,0,0],[0,0,0,3] last -> res_valid pulses at +8,+10,+11 cycles from first acceptance: [10,10,10,10],[2,2,2,2],[12,12,12,12]; no pulse for bubble.
REQ-035 IDLE with w_valid=a_valid=1 -> weight beat accepted, a_ready=0, state LOAD; weights_loaded=0 until 4th row beat.
REQ-036 Assert rst low mid-COMPUTE after 2 vectors -> all outputs at reset values immediately, weights_loaded=0, no subsequent res_valid; a_valid after release -> a_ready=0.
REQ-037 Weight load with w_valid deasserted 3 cycles between rows 1 and 2 -> row counter holds, final weights correct (checked via identity result [5,6,7,8] for a=[5,6,7,8]).

Source files
------------

// File: rtl/systolic_array_ws.sv
// Weight-stationary NxN systolic array: activations flow right, partial sums flow down,
// with input skew and output de-skew so each vector's results appear together 2N cycles after acceptance.
module systolic_array_ws #(
    parameter int WIDTH     = 16,
    parameter int N         = 4,
    parameter int ACC_WIDTH = 2*WIDTH + $clog2(N)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            w_valid,
    output logic                            w_ready,
    input  logic [N-1:0][WIDTH-1:0]         w_row,
    input  logic                            a_valid,
    output logic                            a_ready,
    input  logic [N-1:0][WIDTH-1:0]         a_in,
    input  logic                            a_last,
    output logic                            res_valid,
    output logic [N-1:0][ACC_WIDTH-1:0]     res_out,
    output logic                            busy,
    output logic                            weights_loaded,
    output logic [1:0]                      dbg_state
);

    localparam int ROW_W = $clog2(N);
    localparam int CNT_W = $clog2(2*N + 1);

    // Handshake: a beat transfers on a rising edge where valid && ready; ready never depends on
    // anything but state and w_valid, and valid must hold its payload until that edge.
    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_e;

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [CNT_W-1:0]   drain_q, drain_d;
    logic               wl_q, wl_d;
    logic               w_we;
    logic               a_fire;

    logic signed [WIDTH-1:0]     w_q    [N][N];
    logic signed [WIDTH-1:0]     act_q  [N][N-1];
    logic signed [ACC_WIDTH-1:0] psum_q [N][N];
    logic signed [WIDTH-1:0]     a_data [N];
    logic signed [WIDTH-1:0]     feed   [N];
    logic signed [WIDTH-1:0]     pe_act [N][N];
    logic signed [2*WIDTH-1:0]   prod   [N][N];
    logic signed [ACC_WIDTH-1:0] pe_sum [N][N];
    logic signed [ACC_WIDTH-1:0] dsk_out [N];

    logic [2*N:0]                vld_q;
    logic [N-1:0][ACC_WIDTH-1:0] res_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        drain_d = drain_q;
        wl_d    = wl_q;
        w_we    = 1'b0;
        w_ready = 1'b0;
        a_ready = 1'b0;
        case (state_q)
            IDLE: begin
                w_ready = 1'b1;
                a_ready = wl_q && !w_valid;
                if (w_valid) begin
                    w_we    = 1'b1;
                    wl_d    = 1'b0;
                    row_d   = ROW_W'(1);
                    state_d = LOAD;
                end else if (a_valid && a_ready) begin
                    drain_d = '0;
                    state_d = a_last ? DRAIN : COMPUTE;
                end
            end
            LOAD: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    w_we = 1'b1;
                    if (row_q == ROW_W'(N-1)) begin
                        row_d   = '0;
                        wl_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            COMPUTE: begin
                a_ready = 1'b1;
                if (a_valid && a_last) begin
                    drain_d = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Stay until the last vector's result has been presented.
                if (drain_q == CNT_W'(2*N)) begin
                    drain_d = '0;
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            drain_q <= '0;
            wl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            drain_q <= drain_d;
            wl_q    <= wl_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    w_q[r][c] <= '0;
        end else if (w_we) begin
            for (int c = 0; c < N; c++)
                w_q[row_q][c] <= w_row[c];
        end
    end

    assign a_fire = a_valid && a_ready;

    // Bubbles enter the grid as zeros; their validity is tracked separately in vld_q.
    always_comb begin
        for (int i = 0; i < N; i++)
            a_data[i] = a_fire ? a_in[i] : '0;
    end

    for (genvar i = 0; i < N; i++) begin : g_skew
        logic signed [WIDTH-1:0] sk_q [i+1];
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int k = 0; k <= i; k++)
                    sk_q[k] <= '0;
            end else begin
                sk_q[0] <= a_data[i];
                for (int k = 1; k <= i; k++)
                    sk_q[k] <= sk_q[k-1];
            end
        end
        assign feed[i] = sk_q[i];
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            pe_act[i][0] = feed[i];
            for (int j = 1; j < N; j++)
                pe_act[i][j] = act_q[i][j-1];
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                prod[i][j] = (2*WIDTH)'(pe_act[i][j]) * (2*WIDTH)'(w_q[i][j]);
        for (int j = 0; j < N; j++)
            pe_sum[0][j] = ACC_WIDTH'(prod[0][j]);
        for (int i = 1; i < N; i++)
            for (int j = 0; j < N; j++)
                pe_sum[i][j] = psum_q[i-1][j] + ACC_WIDTH'(prod[i][j]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++)
                    psum_q[i][j] <= '0;
                for (int j = 0; j < N-1; j++)
                    act_q[i][j] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++)
                    psum_q[i][j] <= pe_sum[i][j];
                for (int j = 0; j < N-1; j++)
                    act_q[i][j] <= pe_act[i][j];
            end
        end
    end

    // Column j finishes j cycles after column 0; delay it by N-1-j to realign.
    for (genvar j = 0; j < N; j++) begin : g_deskew
        if (j == N-1) begin : g_direct
            assign dsk_out[j] = psum_q[N-1][j];
        end else begin : g_chain
            logic signed [ACC_WIDTH-1:0] ds_q [N-1-j];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < N-1-j; k++)
                        ds_q[k] <= '0;
                end else begin
                    ds_q[0] <= psum_q[N-1][j];
                    for (int k = 1; k < N-1-j; k++)
                        ds_q[k] <= ds_q[k-1];
                end
            end
            assign dsk_out[j] = ds_q[N-2-j];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            res_q <= '0;
        end else begin
            vld_q <= {vld_q[2*N-1:0], a_fire};
            if (vld_q[2*N-1]) begin
                for (int j = 0; j < N; j++)
                    res_q[j] <= dsk_out[j];
            end
        end
    end

    assign res_valid      = vld_q[2*N];
    assign res_out        = res_q;
    assign busy           = (state_q != IDLE);
    assign weights_loaded = wl_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_systolic_array_ws.sv
// Bench for systolic_array_ws: directed scenarios plus random batches checked against a
// matrix-vector product model with exact result-cycle expectations.
module tb_systolic_array_ws;

    localparam int N     = 4;
    localparam int WIDTH = 16;
    localparam int ACC   = 2*WIDTH + $clog2(N);
    localparam int LAT   = 2*N;

    typedef logic [N-1:0][WIDTH-1:0] vec_t;
    typedef logic [N-1:0][ACC-1:0]   res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic w_valid = 1'b0, a_valid = 1'b0, a_last = 1'b0;
    vec_t w_row = '0, a_in = '0;
    logic w_ready, a_ready, res_valid, busy, weights_loaded;
    logic [1:0] dbg_state;
    res_t res_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    res_t exp_q[$];
    int   exp_c[$];
    res_t got_q[$];
    int   got_c[$];
    int   wm[N][N];
    int   wt[N][N];

    systolic_array_ws #(.WIDTH(WIDTH), .N(N), .ACC_WIDTH(ACC)) dut (
        .clk(clk), .rst(rst),
        .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
        .a_valid(a_valid), .a_ready(a_ready), .a_in(a_in), .a_last(a_last),
        .res_valid(res_valid), .res_out(res_out),
        .busy(busy), .weights_loaded(weights_loaded), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && res_valid) begin
            got_q.push_back(res_out);
            got_c.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog sim_time=%0t limit=200000", $time);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mkv(input int x0, input int x1, input int x2, input int x3);
        vec_t v;
        v[0] = WIDTH'(x0); v[1] = WIDTH'(x1); v[2] = WIDTH'(x2); v[3] = WIDTH'(x3);
        return v;
    endfunction

    // y[j] = sum_i a[i]*W[i][j], wrapped to ACC bits.
    function automatic res_t model(input vec_t a);
        res_t r;
        longint s;
        for (int j = 0; j < N; j++) begin
            s = 0;
            for (int i = 0; i < N; i++)
                s += longint'($signed(a[i])) * longint'(wm[i][j]);
            r[j] = s[ACC-1:0];
        end
        return r;
    endfunction

    task automatic send_a(input vec_t a, input bit last);
        bit ok;
        ok = 0;
        a_in = a; a_last = last; a_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (a_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (ok) begin
            exp_q.push_back(model(a));
            exp_c.push_back(cyc + 1 + LAT);
        end else begin
            n_cmp++; n_bad++;
            $display("FAIL a_accept_timeout a_ready=%b want 1", a_ready);
        end
        @(posedge clk); #1;
        a_valid = 1'b0; a_last = 1'b0;
    endtask

    task automatic bubble();
        a_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic load_w(input int stall_row, input int stall_n);
        bit ok;
        logic signed [WIDTH-1:0] t;
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < N; j++) w_row[j] = WIDTH'(wt[r][j]);
            w_valid = 1'b1;
            ok = 0;
            for (int k = 0; k < 64; k++) begin
                @(negedge clk);
                if (w_ready) begin ok = 1; break; end
                @(posedge clk); #1;
            end
            if (!ok) begin
                n_cmp++; n_bad++;
                $display("FAIL w_accept_timeout row=%0d w_ready=%b want 1", r, w_ready);
            end
            for (int j = 0; j < N; j++) begin t = WIDTH'(wt[r][j]); wm[r][j] = t; end
            @(posedge clk); #1;
            w_valid = 1'b0;
            if (r == stall_row) begin
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clk);
                    n_cmp++;
                    if (weights_loaded !== 1'b0 || busy !== 1'b1 || w_ready !== 1'b1) begin
                        n_bad++;
                        $display("FAIL load_stall wl=%b busy=%b w_ready=%b want 0 1 1", weights_loaded, busy, w_ready);
                    end
                    @(posedge clk); #1;
                end
            end
        end
        @(negedge clk);
        n_cmp++;
        if (weights_loaded !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL load_done wl=%b busy=%b want 1 0", weights_loaded, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_done_timeout busy=%b want 0", tag, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (res_valid !== 1'b0 || res_out !== '0 || busy !== 1'b0 || weights_loaded !== 1'b0 ||
            a_ready !== 1'b0 || w_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_outputs rv=%b res=%h busy=%b wl=%b ar=%b wr=%b want 0 0 0 0 0 1",
                     res_valid, res_out, busy, weights_loaded, a_ready, w_ready);
        end
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b1; a_in = mkv(1, 2, 3, 4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (a_ready !== 1'b0 || w_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_no_weights a_ready=%b w_ready=%b want 0 1", a_ready, w_ready);
            end
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    task automatic test_identity();
        bit seen;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wt[i][j] = (i == j) ? 1 : 0;
        load_w(-1, 0);
        send_a(mkv(1, 2, 3, 4), 1'b1);
        seen = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk);
            if (res_valid) begin seen = 1; break; end
        end
        n_cmp++;
        if (!seen || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL identity_pulse seen=%b busy=%b want 1 1", seen, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || weights_loaded !== 1'b1) begin
            n_bad++;
            $display("FAIL identity_idle busy=%b rv=%b wl=%b want 0 0 1", busy, res_valid, weights_loaded);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL identity_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) if (k < got_q.size()) begin
            n_cmp++;
            if (got_q[k] !== exp_q[k] || got_c[k] != exp_c[k]) begin
                n_bad++;
                $display("FAIL identity_res[%0d] got %h @%0d want %h @%0d", k, got_q[k], got_c[k], exp_q[k], exp_c[k]);
            end
        end
        exp_q.delete(); exp_c.delete(); got_q.delete(); got_c.delete();
    endtask

    task automatic test_neg_weights();
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wt[i][j] = -1;
        load_w(-1, 0);
        send_a(mkv(32767, 32767, 32767, 32767), 1'b1);
        wait_done("neg");
        n_cmp++;
        if (got_q.size() != 1) begin
            n_bad++;
            $display("FAIL neg_count got %0d want 1", got_q.size());
        end
        for (int k = 0; k < got_q.size() && k < 1; k++) begin
            for (int j = 0; j < N; j++) begin
                n_cmp++;
                if ($signed(got_q[k][j]) !== -34'sd131068 || got_c[k] != exp_c[k]) begin
                    n_bad++;
                    $display("FAIL neg_res[%0d] got %0d @%0d want -131068 @%0d", j, $signed(got_q[k][j]), got_c[k], exp_c[k]);
                end
            end
        end
        exp_q.delete(); exp_c.delete(); got_q.delete(); got_c.delete();
    endtask

    task automatic test_precedence();
        logic signed [WIDTH-1:0] t;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wt[i][j] = i + 1;
        a_valid = 1'b1; a_in = mkv(9, 9, 9, 9); a_last = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < N; j++) w_row[j] = WIDTH'(wt[r][j]);
            w_valid = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (r == 0) begin
                if (a_ready !== 1'b0 || w_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL prec_first a_ready=%b w_ready=%b want 0 1", a_ready, w_ready);
                end
            end else if (busy !== 1'b1 || weights_loaded !== 1'b0 || a_ready !== 1'b0 || w_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL prec_load row=%0d busy=%b wl=%b ar=%b wr=%b want 1 0 0 1",
                         r, busy, weights_loaded, a_ready, w_ready);
            end
            for (int j = 0; j < N; j++) begin t = WIDTH'(wt[r][j]); wm[r][j] = t; end
            @(posedge clk); #1;
            a_valid = 1'b0;
        end
        w_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (weights_loaded !== 1'b1 || busy !== 1'b0 || got_q.size() != 0) begin
            n_bad++;
            $display("FAIL prec_done wl=%b busy=%b results=%0d want 1 0 0", weights_loaded, busy, got_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_bubbles();
        send_a(mkv(1, 1, 1, 1), 1'b0);
        bubble();
        send_a(mkv(2, 0, 0, 0), 1'b0);
        send_a(mkv(0, 0, 0, 3), 1'b1);
        wait_done("bubble");
        n_cmp++;
        if (got_q.size() != 3 || exp_c.size() != 3 ||
            exp_c[1] - exp_c[0] != 2 || exp_c[2] - exp_c[0] != 3) begin
            n_bad++;
            $display("FAIL bubble_count got %0d want 3", got_q.size());
        end
        foreach (exp_q[k]) if (k < got_q.size()) begin
            n_cmp++;
            if (got_q[k] !== exp_q[k] || got_c[k] != exp_c[k]) begin
                n_bad++;
                $display("FAIL bubble_res[%0d] got %h @%0d want %h @%0d", k, got_q[k], got_c[k], exp_q[k], exp_c[k]);
            end
        end
        exp_q.delete(); exp_c.delete(); got_q.delete(); got_c.delete();
    endtask

    task automatic test_stall();
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wt[i][j] = (i == j) ? 1 : 0;
        load_w(1, 3);
        send_a(mkv(5, 6, 7, 8), 1'b1);
        wait_done("stall");
        n_cmp++;
        if (got_q.size() != 1) begin
            n_bad++;
            $display("FAIL stall_count got %0d want 1", got_q.size());
        end
        for (int k = 0; k < got_q.size() && k < 1; k++) begin
            n_cmp++;
            if (got_q[k] !== exp_q[k] || got_c[k] != exp_c[k] ||
                got_q[k][0] !== ACC'(5) || got_q[k][3] !== ACC'(8)) begin
                n_bad++;
                $display("FAIL stall_res got %h @%0d want %h @%0d", got_q[k], got_c[k], exp_q[k], exp_c[k]);
            end
        end
        exp_q.delete(); exp_c.delete(); got_q.delete(); got_c.delete();
    endtask

    task automatic test_random();
        vec_t v;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wt[i][j] = $urandom_range(0, 65535);
        load_w(-1, 0);
        for (int b = 0; b < 2; b++) begin
            for (int n = 0; n < 16; n++) begin
                for (int i = 0; i < N; i++) v[i] = WIDTH'($urandom_range(0, 65535));
                send_a(v, n == 15);
                if ($urandom_range(0, 3) == 0) bubble();
            end
            wait_done("random");
        end
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL random_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) if (k < got_q.size()) begin
            n_cmp++;
            if (got_q[k] !== exp_q[k] || got_c[k] != exp_c[k]) begin
                n_bad++;
                $display("FAIL random_res[%0d] got %h @%0d want %h @%0d", k, got_q[k], got_c[k], exp_q[k], exp_c[k]);
            end
        end
        exp_q.delete(); exp_c.delete(); got_q.delete(); got_c.delete();
    endtask

    task automatic test_reset_mid();
        int bad;
        send_a(mkv(3, 1, 4, 1), 1'b0);
        send_a(mkv(5, 9, 2, 6), 1'b0);
        #3 rst = 1'b0;
        #1;
        n_cmp++;
        if (res_valid !== 1'b0 || res_out !== '0 || busy !== 1'b0 || weights_loaded !== 1'b0 ||
            a_ready !== 1'b0 || w_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL resetmid_outputs rv=%b res=%h busy=%b wl=%b ar=%b wr=%b want 0 0 0 0 0 1",
                     res_valid, res_out, busy, weights_loaded, a_ready, w_ready);
        end
        exp_q.delete(); exp_c.delete(); got_q.delete(); got_c.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        a_valid = 1'b1; a_in = mkv(7, 7, 7, 7);
        bad = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk);
            if (a_ready !== 1'b0) bad++;
        end
        a_valid = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL resetmid_a_ready cycles_ready=%0d want 0", bad);
        end
        n_cmp++;
        if (got_q.size() != 0) begin
            n_bad++;
            $display("FAIL resetmid_results got %0d want 0", got_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_neg_weights();
        test_precedence();
        test_bubbles();
        test_stall();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
